// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: a - b is formed as a + ~b + 1, CHUNK bits
// per clock from the LSB chunk upward, with the carry held in a register.
// The final carry, running zero flag and result MSB give agb/aeb/alb in
// unsigned or two's-complement signed mode.
module seq_magnitude_comparator #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agb,
    output logic             aeb,
    output logic             alb,
    output logic [WIDTH-1:0] diff
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               agb_q, agb_d;
    logic               aeb_q, aeb_d;
    logic               alb_q, alb_d;

    int                 base;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     sum;
    logic               z_fin;
    logic               n_fin;
    logic               v_fin;

    // Next-state, chunk adder and flag evaluation
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        agb_d   = agb_q;
        aeb_d   = aeb_q;
        alb_d   = alb_q;

        base    = int'(idx_q) * CHUNK;
        a_chunk = CHUNK'(a_q >> base);
        b_chunk = CHUNK'(b_q >> base);
        sum     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry_q};
        z_fin   = zero_q & (sum[CHUNK-1:0] == '0);
        n_fin   = sum[CHUNK-1];
        v_fin   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ n_fin);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    mode_d  = signed_mode & (SIGNED_EN != 0);
                    carry_d = 1'b1;
                    zero_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                diff_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                zero_d  = z_fin;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    aeb_d   = z_fin;
                    if (mode_q) begin
                        alb_d = n_fin ^ v_fin;
                        agb_d = ~(n_fin ^ v_fin) & ~z_fin;
                    end else begin
                        alb_d = ~sum[CHUNK];
                        agb_d = sum[CHUNK] & ~z_fin;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared by async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
            diff_q  <= '0;
            agb_q   <= 1'b0;
            aeb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            agb_q   <= agb_d;
            aeb_q   <= aeb_d;
            alb_q   <= alb_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign agb  = agb_q;
    assign aeb  = aeb_q;
    assign alb  = alb_q;
    assign diff = diff_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: three instances (CHUNK 4, 16, 1)
// share operands; each has its own start, expected-result queue and monitor.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start16, start1;
    logic        signed_mode;
    logic [15:0] a, b;

    logic        busy4, done4, agb4, aeb4, alb4;
    logic [15:0] diff4;
    logic        busy16, done16, agb16, aeb16, alb16;
    logic [15:0] diff16;
    logic        busy1, done1, agb1, aeb1, alb1;
    logic [15:0] diff1;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy4), .done(done4), .agb(agb4), .aeb(aeb4),
        .alb(alb4), .diff(diff4));

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16), .SIGNED_EN(1)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy16), .done(done16), .agb(agb16), .aeb(aeb16),
        .alb(alb16), .diff(diff16));

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1), .SIGNED_EN(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .agb(agb1), .aeb(aeb1),
        .alb(alb1), .diff(diff1));

    typedef struct {
        logic [15:0] diff;
        logic        agb;
        logic        aeb;
        logic        alb;
        int          t0;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    exp_t q1[$];

    int       cyc = 0;
    int       total = 0;
    int       passed = 0;
    logic [2:0] hold_exp[3];
    int       last_done[3];
    int       prev_done[3];
    int       nchunk[3] = '{4, 1, 16};
    string    nm[3] = '{"c4", "c16", "c1"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic mv);
        exp_t e;
        logic lt;
        e.diff = av - bv;
        if (mv) lt = ($signed(av) < $signed(bv));
        else    lt = (av < bv);
        e.aeb = (av == bv);
        e.alb = lt;
        e.agb = !lt && (av != bv);
        e.t0  = 0;
        return e;
    endfunction

    task automatic mon(input int id, input logic dn, input logic ag, input logic ae,
                       input logic al, input logic [15:0] df);
        exp_t e;
        int   sz;
        if (!rst_n) return;
        case (id)
            0:       sz = q4.size();
            1:       sz = q16.size();
            default: sz = q1.size();
        endcase
        if (dn) begin
            chk($sformatf("%s_done_expected", nm[id]), 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                case (id)
                    0:       e = q4.pop_front();
                    1:       e = q16.pop_front();
                    default: e = q1.pop_front();
                endcase
                chk($sformatf("%s_diff", nm[id]), 32'(df), 32'(e.diff));
                chk($sformatf("%s_flags", nm[id]), 32'({ag, ae, al}), 32'({e.agb, e.aeb, e.alb}));
                chk($sformatf("%s_latency", nm[id]), 32'(cyc - e.t0), 32'(nchunk[id]));
                hold_exp[id]  = {e.agb, e.aeb, e.alb};
                prev_done[id] = last_done[id];
                last_done[id] = cyc;
            end
        end else begin
            chk($sformatf("%s_flag_hold", nm[id]), 32'({ag, ae, al}), 32'(hold_exp[id]));
        end
    endtask

    always @(negedge clk) begin
        mon(0, done4, agb4, aeb4, alb4, diff4);
        mon(1, done16, agb16, aeb16, alb16, diff16);
        mon(2, done1, agb1, aeb1, alb1, diff1);
    end

    task automatic launch(input logic [2:0] mask, input logic [15:0] av, input logic [15:0] bv,
                          input logic mv, input logic hold);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        signed_mode = mv;
        start4  = mask[0];
        start16 = mask[1];
        start1  = mask[2];
        @(posedge clk);
        #1;
        e = model(av, bv, mv);
        e.t0 = cyc;
        if (mask[0]) q4.push_back(e);
        if (mask[1]) q16.push_back(e);
        if (mask[2]) q1.push_back(e);
        if (!hold) begin
            start4  = 1'b0;
            start16 = 1'b0;
            start1  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q4.size() + q16.size() + q1.size()) != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("result_timeout", 32'(q4.size() + q16.size() + q1.size()), 32'd0);
        q4.delete();
        q16.delete();
        q1.delete();
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_c4_busy"}, 32'(busy4), 0);
        chk({tag, "_c4_done"}, 32'(done4), 0);
        chk({tag, "_c4_flags"}, 32'({agb4, aeb4, alb4}), 0);
        chk({tag, "_c4_diff"}, 32'(diff4), 0);
        chk({tag, "_c16_busy_done"}, 32'({busy16, done16}), 0);
        chk({tag, "_c16_flags_diff"}, 32'({agb16, aeb16, alb16, diff16}), 0);
        chk({tag, "_c1_busy_done"}, 32'({busy1, done1}), 0);
        chk({tag, "_c1_flags_diff"}, 32'({agb1, aeb1, alb1, diff1}), 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rm;
        rst_n = 1'b0;
        start4 = 1'b0; start16 = 1'b0; start1 = 1'b0;
        signed_mode = 1'b0;
        a = '0; b = '0;
        for (int i = 0; i < 3; i++) begin
            hold_exp[i]  = '0;
            last_done[i] = 0;
            prev_done[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        rst_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on all three configurations
        launch(3'b111, 16'h1234, 16'h1233, 1'b0, 1'b0); wait_idle();
        launch(3'b111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0); wait_idle();
        launch(3'b111, 16'h0000, 16'h0001, 1'b0, 1'b0); wait_idle();
        launch(3'b111, 16'h8000, 16'h7FFF, 1'b1, 1'b0); wait_idle();
        launch(3'b111, 16'h8000, 16'h7FFF, 1'b0, 1'b0); wait_idle();
        launch(3'b111, 16'h7FFF, 16'h8000, 1'b1, 1'b0); wait_idle();

        // Start held through RUN with moving operands, then a back-to-back start
        launch(3'b001, 16'h00F0, 16'h0F00, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            signed_mode = ~signed_mode;
        end
        launch(3'b001, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        wait_idle();
        chk("c4_b2b_spacing", 32'(last_done[0] - prev_done[0]), 32'd5);

        // Reset in the second RUN cycle aborts the operation
        launch(3'b001, 16'h4321, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete(); q16.delete(); q1.delete();
        for (int i = 0; i < 3; i++) hold_exp[i] = '0;
        #1;
        rst_check("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        launch(3'b111, 16'h0005, 16'hFFFB, 1'b1, 1'b0); wait_idle();

        // Random operands and modes
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = (($urandom % 5) == 0) ? ra : 16'($urandom);
            rm = 1'($urandom);
            launch(3'b111, ra, rb, rm, 1'b0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
